// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 constants and load helpers for the LCD write controller
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_NIB,
      INIT_WAIT,
      IDLE,
      HI_NIB,
      GAP,
      LO_NIB,
      POST_WAIT
   } lcd_state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } strobe_phase_t;

   localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
   localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   localparam logic LCD_RW_WRITE = 1'b0;

   // A phase of N cycles loads N-1 and leaves on zero; N=0 still lasts one cycle.
   function automatic int load_val(input int cycles);
      return (cycles > 0) ? cycles - 1 : 0;
   endfunction

   function automatic logic is_long_cmd(input logic [7:0] code);
      return (code == CMD_CLEAR) || (code == CMD_HOME) || (code == CMD_HOME_ALT);
   endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// rtl/lcd_nibble_strobe.sv - one setup / E-high / hold strobe of a 4-bit nibble onto the LCD pins
module lcd_nibble_strobe
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES = 2,
   parameter int E_CYCLES     = 12,
   parameter int HOLD_CYCLES  = 2,
   parameter int CNT_W        = 20
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iStart,
   input  logic [3:0] iNibble,
   input  logic       iRS,
   output logic       oDone,
   output logic       oLCD_E,
   output logic       oLCD_RS,
   output logic [3:0] oLCD_Data
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(load_val(SETUP_CYCLES));
   localparam logic [CNT_W-1:0] E_LD     = CNT_W'(load_val(E_CYCLES));
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(load_val(HOLD_CYCLES));

   strobe_phase_t    phase, phase_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             e_next;

   always_comb begin
      phase_next = phase;
      cnt_next   = cnt;
      e_next     = 1'b0;
      if (iStart) begin
         phase_next = PH_SETUP;
         cnt_next   = SETUP_LD;
      end else begin
         case (phase)
            PH_SETUP: begin
               if (cnt == '0) begin
                  phase_next = PH_STROBE;
                  cnt_next   = E_LD;
                  e_next     = 1'b1;
               end else begin
                  cnt_next = cnt - CNT_ONE;
               end
            end
            PH_STROBE: begin
               if (cnt == '0) begin
                  phase_next = PH_HOLD;
                  cnt_next   = HOLD_LD;
               end else begin
                  cnt_next = cnt - CNT_ONE;
                  e_next   = 1'b1;
               end
            end
            PH_HOLD: begin
               if (cnt == '0) begin
                  phase_next = PH_IDLE;
               end else begin
                  cnt_next = cnt - CNT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // RS and data are latched only on start, so they persist after the hold phase.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         phase     <= PH_IDLE;
         cnt       <= '0;
         oLCD_E    <= 1'b0;
         oLCD_RS   <= 1'b0;
         oLCD_Data <= 4'h0;
      end else begin
         phase  <= phase_next;
         cnt    <= cnt_next;
         oLCD_E <= e_next;
         if (iStart) begin
            oLCD_RS   <= iRS;
            oLCD_Data <= iNibble;
         end
      end
   end

   assign oDone = (phase == PH_HOLD) && (cnt == '0);

endmodule

// File: rtl/lcd_write_ctrl.sv
// rtl/lcd_write_ctrl.sv - byte-wide HD44780 4-bit write controller
// Optional power-on init sequence: LCD_WRITE_CTRL_POWERON_INIT_EN.
module lcd_write_ctrl
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES     = 2,
   parameter int E_CYCLES         = 12,
   parameter int HOLD_CYCLES      = 2,
   parameter int GAP_CYCLES       = 50,
   parameter int WAIT_CYCLES      = 2000,
   parameter int LONG_WAIT_CYCLES = 82000,
   parameter int POWERON_CYCLES   = 750000,
   parameter int CNT_W            = 20
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iValid,
   input  logic [7:0] iData,
   input  logic       iIsCommand,
   output logic       oReady,
   output logic       oBusy,
   output logic       oLCD_E,
   output logic       oLCD_RS,
   output logic       oLCD_RW,
   output logic [3:0] oLCD_Data
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(load_val(GAP_CYCLES));
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(load_val(WAIT_CYCLES));
   localparam logic [CNT_W-1:0] LONG_LD = CNT_W'(load_val(LONG_WAIT_CYCLES));
`ifdef LCD_WRITE_CTRL_POWERON_INIT_EN
   localparam logic [CNT_W-1:0] PWR_LD       = CNT_W'(load_val(POWERON_CYCLES));
   localparam logic [CNT_W-1:0] INIT_LONG_LD = CNT_W'(load_val(LONG_WAIT_CYCLES * 5 / 2));
   localparam logic [CNT_W-1:0] INIT_MID_LD  = CNT_W'(load_val(WAIT_CYCLES * 5 / 2));
`endif

   lcd_state_t       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [3:0]       lo_nib_q;
   logic             rs_q;
   logic             long_q;
   logic             accept;
   logic             start;
   logic [3:0]       start_nib;
   logic             start_rs;
   logic             done;
`ifdef LCD_WRITE_CTRL_POWERON_INIT_EN
   logic [1:0]       init_idx, init_idx_next;
`endif

   assign accept = (state == IDLE) && oReady && iValid;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      start      = 1'b0;
      start_nib  = lo_nib_q;
      start_rs   = rs_q;
`ifdef LCD_WRITE_CTRL_POWERON_INIT_EN
      init_idx_next = init_idx;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = HI_NIB;
               start      = 1'b1;
               start_nib  = iData[7:4];
               start_rs   = !iIsCommand;
            end
         end
         HI_NIB: begin
            if (done) begin
               state_next = GAP;
               cnt_next   = GAP_LD;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_next = LO_NIB;
               start      = 1'b1;
            end else begin
               cnt_next = cnt - CNT_ONE;
            end
         end
         LO_NIB: begin
            if (done) begin
               state_next = POST_WAIT;
               cnt_next   = long_q ? LONG_LD : WAIT_LD;
            end
         end
         POST_WAIT: begin
            if (cnt == '0) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CNT_ONE;
            end
         end
`ifdef LCD_WRITE_CTRL_POWERON_INIT_EN
         PWR_WAIT: begin
            if (cnt == '0) begin
               state_next    = INIT_NIB;
               start         = 1'b1;
               start_nib     = INIT_NIB_8BIT;
               start_rs      = 1'b0;
               init_idx_next = 2'd0;
            end else begin
               cnt_next = cnt - CNT_ONE;
            end
         end
         INIT_NIB: begin
            if (done) begin
               state_next = INIT_WAIT;
               case (init_idx)
                  2'd0:    cnt_next = INIT_LONG_LD;
                  2'd1:    cnt_next = INIT_MID_LD;
                  default: cnt_next = WAIT_LD;
               endcase
            end
         end
         INIT_WAIT: begin
            if (cnt != '0) begin
               cnt_next = cnt - CNT_ONE;
            end else if (init_idx == 2'd3) begin
               state_next = IDLE;
            end else begin
               // Three 8-bit wake-ups, then the switch into 4-bit mode.
               state_next    = INIT_NIB;
               start         = 1'b1;
               start_nib     = (init_idx == 2'd2) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
               start_rs      = 1'b0;
               init_idx_next = init_idx + 2'd1;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
`ifdef LCD_WRITE_CTRL_POWERON_INIT_EN
         state    <= PWR_WAIT;
         cnt      <= PWR_LD;
         init_idx <= 2'd0;
`else
         state    <= IDLE;
         cnt      <= '0;
`endif
         oReady   <= 1'b0;
         oBusy    <= 1'b1;
         oLCD_RW  <= LCD_RW_WRITE;
         lo_nib_q <= 4'h0;
         rs_q     <= 1'b0;
         long_q   <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         oReady  <= (state_next == IDLE);
         oBusy   <= (state_next != IDLE);
         oLCD_RW <= LCD_RW_WRITE;
`ifdef LCD_WRITE_CTRL_POWERON_INIT_EN
         init_idx <= init_idx_next;
`endif
         if (accept) begin
            lo_nib_q <= iData[3:0];
            rs_q     <= !iIsCommand;
            long_q   <= iIsCommand && is_long_cmd(iData);
         end
      end
   end

   lcd_nibble_strobe #(
      .SETUP_CYCLES (SETUP_CYCLES),
      .E_CYCLES     (E_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .CNT_W        (CNT_W)
   ) u_strobe (
      .Clock     (Clock),
      .Reset     (Reset),
      .iStart    (start),
      .iNibble   (start_nib),
      .iRS       (start_rs),
      .oDone     (done),
      .oLCD_E    (oLCD_E),
      .oLCD_RS   (oLCD_RS),
      .oLCD_Data (oLCD_Data)
   );

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// tb/tb_lcd_write_ctrl.sv - scoreboard bench for lcd_write_ctrl (init path under LCD_WRITE_CTRL_POWERON_INIT_EN)
`timescale 1ns/1ps
module tb_lcd_write_ctrl;

   localparam int S_C = 2, E_C = 4, H_C = 2, G_C = 10, W_C = 40, L_C = 200, P_C = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       is_cmd = 1'b0;
   logic       ready, busy, lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_data;

   lcd_write_ctrl #(
      .SETUP_CYCLES     (S_C),
      .E_CYCLES         (E_C),
      .HOLD_CYCLES      (H_C),
      .GAP_CYCLES       (G_C),
      .WAIT_CYCLES      (W_C),
      .LONG_WAIT_CYCLES (L_C),
      .POWERON_CYCLES   (P_C),
      .CNT_W            (20)
   ) dut (
      .Clock      (clk),
      .Reset      (rst),
      .iValid     (valid),
      .iData      (data),
      .iIsCommand (is_cmd),
      .oReady     (ready),
      .oBusy      (busy),
      .oLCD_E     (lcd_e),
      .oLCD_RS    (lcd_rs),
      .oLCD_RW    (lcd_rw),
      .oLCD_Data  (lcd_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      logic       rs;
      logic [3:0] nib;
   } nib_t;

   typedef struct {
      logic [7:0] d;
      logic       c;
      logic       rs;
      logic [3:0] hi;
      logic [3:0] lo;
      int         busy;
   } vec_t;

   // Expected RS, nibbles and busy length worked out by hand: 66 = 2*(2+4+2)+10+40, 226 = 66-40+200.
   vec_t vecs [9] = '{
      '{8'h41, 1'b0, 1'b1, 4'h4, 4'h1, 66},
      '{8'h01, 1'b1, 1'b0, 4'h0, 4'h1, 226},
      '{8'h80, 1'b1, 1'b0, 4'h8, 4'h0, 66},
      '{8'h03, 1'b1, 1'b0, 4'h0, 4'h3, 226},
      '{8'h04, 1'b1, 1'b0, 4'h0, 4'h4, 66},
      '{8'h01, 1'b0, 1'b1, 4'h0, 4'h1, 66},
      '{8'h48, 1'b0, 1'b1, 4'h4, 4'h8, 66},
      '{8'h69, 1'b0, 1'b1, 4'h6, 4'h9, 66},
      '{8'h21, 1'b0, 1'b1, 4'h2, 4'h1, 66}
   };

   nib_t exp_nib [$];
   int   exp_busy [$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one nibble per E pulse and one busy length per busy stretch.
   initial begin
      logic prev_e;
      int   e_len;
      int   busy_len;
      nib_t cur;
      prev_e   = 1'b0;
      e_len    = 0;
      busy_len = 0;
      cur      = '{1'b0, 4'h0};
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            e_len    = 0;
            busy_len = 0;
            prev_e   = lcd_e;
         end else begin
            if (lcd_e && !prev_e) begin
               if (exp_nib.size() == 0) begin
                  check("unexpected_e_pulse", 32'd1, 32'd0);
               end else begin
                  cur = exp_nib.pop_front();
                  check("e_rs", lcd_rs, cur.rs);
                  check("e_data", lcd_data, cur.nib);
               end
               e_len = 1;
            end else if (lcd_e) begin
               e_len++;
            end else if (prev_e) begin
               check("e_width", e_len, E_C);
               check("data_hold_after_e", lcd_data, cur.nib);
            end
            prev_e = lcd_e;
            check("busy_is_not_ready", busy, !ready);
            if (!ready) begin
               busy_len++;
            end else if (busy_len > 0) begin
               if (exp_busy.size() == 0) check("unexpected_busy", busy_len, 0);
               else check("busy_len", busy_len, exp_busy.pop_front());
               busy_len = 0;
            end
         end
      end
   end

   task automatic send(input int i, input bit hold, output int acc_cyc);
      int t;
      t      = 0;
      data   = vecs[i].d;
      is_cmd = vecs[i].c;
      valid  = 1'b1;
      while (!ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      acc_cyc = cyc;
      if (!ready) begin
         check("ready_timeout", 32'd0, 32'd1);
      end else begin
         exp_nib.push_back(nib_t'{vecs[i].rs, vecs[i].hi});
         exp_nib.push_back(nib_t'{vecs[i].rs, vecs[i].lo});
         exp_busy.push_back(vecs[i].busy);
      end
      @(negedge clk);
      if (!hold) valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((!ready || exp_nib.size() != 0 || exp_busy.size() != 0) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) check("idle_timeout", t, 0);
   endtask

`ifdef LCD_WRITE_CTRL_POWERON_INIT_EN
   logic [3:0] init_nib_exp [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
   // Rise-to-rise spacing = 2+4+2 + init wait (500, 100, 40).
   int         init_gap_exp [3] = '{508, 108, 48};
`endif

   initial begin
      int a0, a1, a2, dummy;
      int t, nrise, ecount;
      logic prev;
      a0 = 0; a1 = 0; a2 = 0; dummy = 0;

      repeat (3) @(negedge clk);
      check("reset_e", lcd_e, 1'b0);
      check("reset_rs", lcd_rs, 1'b0);
      check("reset_rw", lcd_rw, 1'b0);
      check("reset_data", lcd_data, 4'h0);
      check("reset_ready", ready, 1'b0);
      check("reset_busy", busy, 1'b1);

`ifdef LCD_WRITE_CTRL_POWERON_INIT_EN
      begin
         int k, first_rise, last_rise;
         rst = 1'b0;
         k = 1; nrise = 0; first_rise = 0; last_rise = 0; prev = 1'b0;
         while (!ready && k < 2000) begin
            @(negedge clk);
            k++;
            if (lcd_e && !prev) begin
               if (nrise < 4) begin
                  check("init_nibble", lcd_data, init_nib_exp[nrise]);
                  check("init_rs", lcd_rs, 1'b0);
                  if (nrise == 0) first_rise = k;
                  else check("init_spacing", k - last_rise, init_gap_exp[nrise-1]);
               end
               nrise++;
               last_rise = k;
            end
            prev = lcd_e;
         end
         check("init_first_rise", first_rise, 103);
         check("init_pulse_count", nrise, 4);
         check("init_last_spacing", k - last_rise, 46);
         check("init_ready_cycle", k, 813);
      end
`else
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", ready, 1'b1);
      check("busy_after_reset", busy, 1'b0);
`endif

      mon_en = 1'b1;
      send(0, 1'b0, dummy); wait_idle();
      send(1, 1'b0, dummy); wait_idle();

      send(2, 1'b0, dummy);
      repeat (3) begin
         repeat (14) @(negedge clk);
         data = 8'h55; is_cmd = 1'b1; valid = 1'b1;
         @(negedge clk);
         valid = 1'b0;
      end
      wait_idle();

      for (int i = 3; i < 6; i++) begin
         send(i, 1'b0, dummy);
         wait_idle();
      end

      send(6, 1'b1, a0);
      send(7, 1'b1, a1);
      send(8, 1'b0, a2);
      check("b2b_spacing_1", a1 - a0, 67);
      check("b2b_spacing_2", a2 - a1, 67);
      wait_idle();
      check("nib_queue_empty", exp_nib.size(), 0);
      check("busy_queue_empty", exp_busy.size(), 0);

`ifndef LCD_WRITE_CTRL_POWERON_INIT_EN
      mon_en = 1'b0;
      data = 8'h41; is_cmd = 1'b0; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      t = 0; nrise = 0; prev = 1'b0;
      while (nrise < 2 && t < 200) begin
         @(negedge clk);
         t++;
         if (lcd_e && !prev) nrise++;
         prev = lcd_e;
      end
      check("second_pulse_seen", nrise, 2);
      rst = 1'b1;
      @(negedge clk);
      check("abort_e_low", lcd_e, 1'b0);
      check("abort_ready_low", ready, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready_after_release", ready, 1'b1);
      ecount = 0;
      repeat (80) begin
         @(negedge clk);
         if (lcd_e) ecount++;
      end
      check("abort_no_e_after", ecount, 0);
      check("abort_ready_stays", ready, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
      $fatal(1);
   end

endmodule
